// File: rtl/cruce_pkg.sv
// Shared types and default timing for the control_cruce intersection controller.
// The PEATON state only exists when CRUCE_PEATON_EN is defined.
package cruce_pkg;

    localparam int VERDE_A_TICS_DEF   = 20;
    localparam int VERDE_B_TICS_DEF   = 20;
    localparam int AMARILLO_TICS_DEF  = 3;
    localparam int TODO_ROJO_TICS_DEF = 2;
    localparam int PEATON_TICS_DEF    = 10;
    localparam int CNT_W_DEF          = 8;

    typedef enum logic [2:0] {
        TODO_ROJO_B = 3'd0,
        VERDE_A     = 3'd1,
        AMARILLO_A  = 3'd2,
        TODO_ROJO_A = 3'd3,
`ifdef CRUCE_PEATON_EN
        PEATON      = 3'd4,
`endif
        VERDE_B     = 3'd5,
        AMARILLO_B  = 3'd6
    } estado_t;

    typedef struct packed {
        logic rojo_a;
        logic amarillo_a;
        logic verde_a;
        logic rojo_b;
        logic amarillo_b;
        logic verde_b;
        logic peaton_verde;
    } luces_t;

    // Lamp decode from state; anything unrecognised falls back to all-red.
    function automatic luces_t decodificar(input estado_t e);
        luces_t l;
        l.rojo_a       = 1'b1;
        l.amarillo_a   = 1'b0;
        l.verde_a      = 1'b0;
        l.rojo_b       = 1'b1;
        l.amarillo_b   = 1'b0;
        l.verde_b      = 1'b0;
        l.peaton_verde = 1'b0;
        case (e)
            VERDE_A: begin
                l.rojo_a  = 1'b0;
                l.verde_a = 1'b1;
            end
            AMARILLO_A: begin
                l.rojo_a     = 1'b0;
                l.amarillo_a = 1'b1;
            end
            VERDE_B: begin
                l.rojo_b  = 1'b0;
                l.verde_b = 1'b1;
            end
            AMARILLO_B: begin
                l.rojo_b     = 1'b0;
                l.amarillo_b = 1'b1;
            end
`ifdef CRUCE_PEATON_EN
            PEATON: begin
                l.peaton_verde = 1'b1;
            end
`endif
            default: begin
                l.rojo_a = 1'b1;
                l.rojo_b = 1'b1;
            end
        endcase
        return l;
    endfunction

endpackage

// File: rtl/control_cruce_temporizador.sv
// Phase down-counter: loads on request, decrements on each tick and parks at zero.
module temporizador #(
    parameter int               CNT_W   = 8,
    parameter logic [CNT_W-1:0] RST_VAL = {CNT_W{1'b0}}
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             tick_en,
    output logic [CNT_W-1:0] count,
    output logic             cero
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: a load wins over a tick; zero is held until the next load.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (tick_en && (count_q != {CNT_W{1'b0}})) begin
            count_d = count_q - CNT_W'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Count register with synchronous reset to the power-on phase length.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= RST_VAL;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign cero  = (count_q == {CNT_W{1'b0}});

endmodule

// File: rtl/control_cruce.sv
// Two-road traffic light controller with optional pedestrian phase.
// Define CRUCE_PEATON_EN to build the PEATON phase and the pedestrian request latch.
module control_cruce
    import cruce_pkg::*;
#(
    parameter int VERDE_A_TICS   = VERDE_A_TICS_DEF,
    parameter int VERDE_B_TICS   = VERDE_B_TICS_DEF,
    parameter int AMARILLO_TICS  = AMARILLO_TICS_DEF,
    parameter int TODO_ROJO_TICS = TODO_ROJO_TICS_DEF,
    parameter int PEATON_TICS    = PEATON_TICS_DEF,
    parameter int CNT_W          = CNT_W_DEF
) (
    input  logic clock,
    input  logic reset,
    input  logic tick_en,
    input  logic sensor_b,
    input  logic peaton_req,
    output logic rojo_a,
    output logic amarillo_a,
    output logic verde_a,
    output logic rojo_b,
    output logic amarillo_b,
    output logic verde_b,
    output logic peaton_verde,
    output logic peaton_ack
);

    localparam logic [CNT_W-1:0] CARGA_VA  = CNT_W'(VERDE_A_TICS - 1);
    localparam logic [CNT_W-1:0] CARGA_VB  = CNT_W'(VERDE_B_TICS - 1);
    localparam logic [CNT_W-1:0] CARGA_AM  = CNT_W'(AMARILLO_TICS - 1);
    localparam logic [CNT_W-1:0] CARGA_TR  = CNT_W'(TODO_ROJO_TICS - 1);
    localparam logic [CNT_W-1:0] CARGA_PEA = CNT_W'(PEATON_TICS - 1);

    // Reload value for the phase being entered.
    function automatic logic [CNT_W-1:0] carga(input estado_t e);
        case (e)
            VERDE_A:     return CARGA_VA;
            AMARILLO_A:  return CARGA_AM;
            VERDE_B:     return CARGA_VB;
            AMARILLO_B:  return CARGA_AM;
`ifdef CRUCE_PEATON_EN
            PEATON:      return CARGA_PEA;
`endif
            default:     return CARGA_TR;
        endcase
    endfunction

    estado_t          estado_q;
    estado_t          estado_d;
    luces_t           luces_q;
    luces_t           luces_d;
    logic             ack_q;
    logic             ack_d;
    logic             pendiente_act;
    logic             carga_en;
    logic [CNT_W-1:0] carga_val;
    logic [CNT_W-1:0] unused_cuenta;
    logic             cero;
    logic             expira;

    temporizador #(
        .CNT_W   (CNT_W),
        .RST_VAL (CARGA_TR)
    ) u_temporizador (
        .clock    (clock),
        .reset    (reset),
        .load     (carga_en),
        .load_val (carga_val),
        .tick_en  (tick_en),
        .count    (unused_cuenta),
        .cero     (cero)
    );

    assign expira = tick_en && cero;

`ifdef CRUCE_PEATON_EN
    logic pendiente_q;
    logic pendiente_d;
    logic entra_peaton;

    assign entra_peaton  = (estado_d == PEATON) && (estado_q != PEATON);
    assign pendiente_act = pendiente_q;

    // Pending-request latch; clearing on PEATON entry beats a coincident request.
    always_comb begin
        pendiente_d = pendiente_q;
        if (entra_peaton) begin
            pendiente_d = 1'b0;
        end else if (peaton_req && (estado_q != PEATON)) begin
            pendiente_d = 1'b1;
        end else begin
            pendiente_d = pendiente_q;
        end
    end

    // Pending-request register.
    always_ff @(posedge clock) begin
        if (reset) begin
            pendiente_q <= 1'b0;
        end else begin
            pendiente_q <= pendiente_d;
        end
    end

    assign ack_d = entra_peaton;
`else
    logic unused_peaton;

    assign unused_peaton = peaton_req;
    assign pendiente_act = 1'b0;
    assign ack_d         = 1'b0;
`endif

    // Next-state logic; VERDE_A keeps re-evaluating at zero until there is demand.
    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            TODO_ROJO_B: begin
                if (expira) estado_d = VERDE_A;
                else        estado_d = estado_q;
            end
            VERDE_A: begin
                if (expira && (sensor_b || pendiente_act)) estado_d = AMARILLO_A;
                else                                        estado_d = estado_q;
            end
            AMARILLO_A: begin
                if (expira) estado_d = TODO_ROJO_A;
                else        estado_d = estado_q;
            end
            TODO_ROJO_A: begin
`ifdef CRUCE_PEATON_EN
                if (expira) estado_d = pendiente_act ? PEATON : VERDE_B;
                else        estado_d = estado_q;
`else
                if (expira) estado_d = VERDE_B;
                else        estado_d = estado_q;
`endif
            end
`ifdef CRUCE_PEATON_EN
            PEATON: begin
                if (expira) estado_d = VERDE_B;
                else        estado_d = estado_q;
            end
`endif
            VERDE_B: begin
                if (expira) estado_d = AMARILLO_B;
                else        estado_d = estado_q;
            end
            AMARILLO_B: begin
                if (expira) estado_d = TODO_ROJO_B;
                else        estado_d = estado_q;
            end
            default: begin
                estado_d = TODO_ROJO_B;
            end
        endcase
    end

    assign carga_en  = (estado_d != estado_q);
    assign carga_val = carga(estado_d);
    assign luces_d   = decodificar(estado_d);

    // State and lamp registers; lamps track the state being entered so they align with it.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q <= TODO_ROJO_B;
            luces_q  <= decodificar(TODO_ROJO_B);
            ack_q    <= 1'b0;
        end else begin
            estado_q <= estado_d;
            luces_q  <= luces_d;
            ack_q    <= ack_d;
        end
    end

    assign rojo_a       = luces_q.rojo_a;
    assign amarillo_a   = luces_q.amarillo_a;
    assign verde_a      = luces_q.verde_a;
    assign rojo_b       = luces_q.rojo_b;
    assign amarillo_b   = luces_q.amarillo_b;
    assign verde_b      = luces_q.verde_b;
    assign peaton_verde = luces_q.peaton_verde;
    assign peaton_ack   = ack_q;

endmodule

// File: tb/tb_control_cruce.sv
// Directed bench for control_cruce with default timing parameters.
// Pedestrian expectations follow whether CRUCE_PEATON_EN is defined.
module tb_control_cruce;

    logic clk = 1'b0;
    logic reset;
    logic tick_en;
    logic sensor_b;
    logic peaton_req;
    logic rojo_a, amarillo_a, verde_a, rojo_b, amarillo_b, verde_b;
    logic peaton_verde, peaton_ack;
    logic [7:0] lamps;

    int checks   = 0;
    int failures = 0;
    int div_n    = 1;
    int edge_n   = 0;
    bit mon_en   = 1'b0;

    // {rojo_a, amarillo_a, verde_a, rojo_b, amarillo_b, verde_b, peaton_verde, peaton_ack}
    localparam logic [7:0] L_RR     = 8'b100_100_00;
    localparam logic [7:0] L_GA     = 8'b001_100_00;
    localparam logic [7:0] L_YA     = 8'b010_100_00;
    localparam logic [7:0] L_GB     = 8'b100_001_00;
    localparam logic [7:0] L_YB     = 8'b100_010_00;
    localparam logic [7:0] L_PED    = 8'b100_100_10;
    localparam logic [7:0] L_PEDACK = 8'b100_100_11;

    control_cruce dut (
        .clock        (clk),
        .reset        (reset),
        .tick_en      (tick_en),
        .sensor_b     (sensor_b),
        .peaton_req   (peaton_req),
        .rojo_a       (rojo_a),
        .amarillo_a   (amarillo_a),
        .verde_a      (verde_a),
        .rojo_b       (rojo_b),
        .amarillo_b   (amarillo_b),
        .verde_b      (verde_b),
        .peaton_verde (peaton_verde),
        .peaton_ack   (peaton_ack)
    );

    assign lamps = {rojo_a, amarillo_a, verde_a, rojo_b, amarillo_b, verde_b, peaton_verde, peaton_ack};

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            assert ((verde_a & verde_b) === 1'b0) else begin
                failures++;
                $error("FAIL both_green: verde_a=%b verde_b=%b required not both 1", verde_a, verde_b);
            end
        end
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Checks n consecutive clocks of one lamp pattern, advancing one edge per clock.
    task automatic phase(input string tag, input logic [7:0] exp, input int n);
        for (int i = 0; i < n; i++) begin
            chk(tag, lamps, exp);
            edge_n++;
            tick_en = (div_n == 1) || ((edge_n % div_n) == 0);
            @(posedge clk);
            #1;
        end
    endtask

    // Leaves the bench 1 time unit after the last reset edge (edge 0).
    task automatic do_reset();
        reset      = 1'b1;
        tick_en    = 1'b1;
        sensor_b   = 1'b0;
        peaton_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset", lamps, L_RR);
        reset  = 1'b0;
        edge_n = 0;
        mon_en = 1'b1;
    endtask

    initial begin
        reset      = 1'b1;
        tick_en    = 1'b1;
        sensor_b   = 1'b0;
        peaton_req = 1'b0;

        // Idle main road: green arrives two ticks after reset and stays.
        do_reset();
        phase("s1_rr", L_RR, 2);
        phase("s1_ga_hold", L_GA, 100);

        // Side-road demand cycles through every phase.
        do_reset();
        sensor_b = 1'b1;
        phase("s2_rr0", L_RR, 2);
        phase("s2_ga", L_GA, 20);
        phase("s2_ya", L_YA, 3);
        phase("s2_rra", L_RR, 2);
        phase("s2_gb", L_GB, 20);
        phase("s2_yb", L_YB, 3);
        phase("s2_rrb", L_RR, 2);
        phase("s2_ga2", L_GA, 20);
        phase("s2_ya2", L_YA, 3);
        phase("s2_rra2", L_RR, 2);
        phase("s2_gb2", L_GB, 20);
        phase("s2_yb2", L_YB, 1);

        // Reset in the middle of yellow B.
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        phase("rst_rr", L_RR, 2);
        phase("rst_ga", L_GA, 3);

        // Pedestrian request with no side-road traffic.
        do_reset();
        phase("s3_rr", L_RR, 2);
        phase("s3_ga", L_GA, 25);
        peaton_req = 1'b1;
        phase("s3_pulse", L_GA, 1);
        peaton_req = 1'b0;
`ifdef CRUCE_PEATON_EN
        phase("s3_ga_last", L_GA, 1);
        phase("s3_ya", L_YA, 3);
        phase("s3_rra", L_RR, 1);
        peaton_req = 1'b1;
        phase("s3_rra_entry", L_RR, 1);
        phase("s3_ack", L_PEDACK, 1);
        phase("s3_walk", L_PED, 9);
        peaton_req = 1'b0;
        phase("s3_gb", L_GB, 20);
        phase("s3_yb", L_YB, 3);
        phase("s3_rrb", L_RR, 2);
        phase("s3_ga_nopend", L_GA, 30);
`else
        phase("s3_ignored", L_GA, 30);
        peaton_req = 1'b1;
        phase("s3_held_req", L_GA, 10);
        sensor_b = 1'b1;
        phase("s3_ga_last", L_GA, 1);
        phase("s3_ya", L_YA, 3);
        phase("s3_rra", L_RR, 2);
        phase("s3_gb", L_GB, 20);
        phase("s3_yb", L_YB, 3);
        phase("s3_rrb", L_RR, 2);
        peaton_req = 1'b0;
`endif

        // Tick only every 4th clock: all durations scale by 4.
        div_n = 4;
        do_reset();
        sensor_b = 1'b1;
        phase("s4_rr0", L_RR, 8);
        phase("s4_ga", L_GA, 80);
        phase("s4_ya", L_YA, 12);
        phase("s4_rra", L_RR, 8);
        phase("s4_gb", L_GB, 80);
        phase("s4_yb", L_YB, 12);
        phase("s4_rrb", L_RR, 8);
        phase("s4_ga2", L_GA, 4);
        div_n = 1;

        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
